// File: rtl/restoring_div_32bit.sv
// Iterative signed divider: radix-2 restoring, one quotient bit per clock.
// Results are two's-complement, truncated toward zero, with a start/busy/done handshake.
module restoring_div_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic             zero_div;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (count == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    // Quotient bits are shifted into the low end of dvd as dividend bits leave the top
    assign shifted = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign trial   = {rem[WIDTH-1], shifted} - {1'b0, divisor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            dvd         <= '0;
            rem         <= '0;
            divisor     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= abs_a;
                        divisor  <= abs_b;
                        sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r   <= A[WIDTH-1];
                        zero_div <= (B == '0);
                        rem      <= '0;
                        count    <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                end
                FIX: begin
                    // Divide by zero yields all-ones quotient regardless of operand signs
                    if (zero_div) Quotient <= '1;
                    else          Quotient <= sign_q ? -dvd : dvd;
                    Remainder   <= sign_r ? -rem : rem;
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_32bit.sv
// Randomized self-checking bench for restoring_div_32bit against a plain-arithmetic model.
module tb_restoring_div_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int compared   = 0;
    int mismatched = 0;

    restoring_div_32bit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Truncating signed division computed with 64-bit arithmetic; overflow wraps on truncation
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] eq, er;
        logic        ez;
        int          cycles;
        int          busy_cycles;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        cycles      = 0;
        busy_cycles = 0;
        while (!done && cycles < 100) begin
            busy_cycles += int'(busy);
            if (inject && cycles == 5) begin
                start = 1'b1;
                A     = $urandom;
                B     = $urandom_range(1, 9);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        checkOutput($sformatf("latency %0h/%0h", a, b), 64'(cycles), 64'd33);
        checkOutput($sformatf("busy_len %0h/%0h", a, b), 64'(busy_cycles), 64'd33);
        checkOutput($sformatf("busy_at_done %0h/%0h", a, b), 64'(busy), 64'd0);
        checkOutput($sformatf("quotient %0h/%0h", a, b), 64'(Quotient), 64'(eq));
        checkOutput($sformatf("remainder %0h/%0h", a, b), 64'(Remainder), 64'(er));
        checkOutput($sformatf("div_by_zero %0h/%0h", a, b), 64'(div_by_zero), 64'(ez));
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        ez;
        bit          done_seen;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        checkOutput("reset_quotient", 64'(Quotient), 64'd0);
        checkOutput("reset_remainder", 64'(Remainder), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(-32'sd60, -32'sd3, 1'b0);
        // done must be a single-cycle pulse and results must hold afterwards
        @(posedge clk);
        #1;
        checkOutput("done_pulse_width", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_quotient", 64'(Quotient), 64'd20);

        applyStimulus(32'd6776, 32'd88, 1'b0);
        applyStimulus(-32'sd9901, 32'd99, 1'b0);
        applyStimulus(32'd7, -32'sd2, 1'b0);
        applyStimulus(-32'sd7, 32'd2, 1'b0);
        applyStimulus(32'd98765, 32'd0, 1'b0);
        applyStimulus(32'd5, 32'd1, 1'b0);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0);
        applyStimulus(32'h80000000, 32'd0, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b0);
        applyStimulus(32'd1000, 32'd7, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($signed(32'($urandom_range(0, 20))) - 10);
                1:       rb = $urandom & 32'h0000FFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, 1'b0);
        end

        // Abort a divide with reset partway through the iteration phase
        @(negedge clk);
        start = 1'b1;
        A     = 32'd123456;
        B     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("abort_quotient", 64'(Quotient), 64'd0);
        checkOutput("abort_remainder", 64'(Remainder), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            done_seen |= done;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        model(32'hFFFFFF00, 32'd3, eq, er, ez);
        applyStimulus(32'hFFFFFF00, 32'd3, 1'b0);
        checkOutput("post_abort_model_q", 64'(Quotient), 64'(eq));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/restoring_div_32bit.md
# restoring_div_32bit

Iterative signed integer divider that inverts the tree multiplier: given a dividend and a divisor it returns quotient and remainder. It uses a radix-2 restoring algorithm that produces one quotient bit per clock, so it trades latency for area next to the single-cycle multiplier. A start/busy/done handshake lets the ALU sequencer issue a divide and wait for the result. Semantics are two's-complement, truncating toward zero.

## Interface
- WIDTH, 32, operand/result width in bits; latency scales as WIDTH+1
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  signed dividend, sampled on the accepting edge only
- B  in  WIDTH  signed divisor, sampled on the accepting edge only
- Quotient  out  WIDTH  signed quotient, registered
- Remainder  out  WIDTH  signed remainder, registered
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse, results valid
- div_by_zero  out  1  registered with results, high if B was 0

## Operation
- States: IDLE, CALC, FIX. Reset forces IDLE.
- IDLE: when start=1, the block latches |A| and |B| as unsigned magnitudes, latches sign_q = A[W-1]^B[W-1], sign_r = A[W-1] and the zero flag (B==0), clears the partial remainder, loads the iteration counter with WIDTH-1, and moves to CALC.
- CALC, each cycle:
  - The partial remainder shifts left 1 and takes in the next dividend MSB.
  - trial = rem - |B|, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem = trial and the quotient bit is 1. Otherwise rem is kept and the quotient bit is 0.
  - The counter decrements. After the iteration at count 0, the block goes to FIX.
- FIX:
  - Quotient = sign_q ? -q : q. Remainder = sign_r ? -r : r.
  - The block asserts done and div_by_zero, then returns to IDLE.
- Arithmetic rules:
  - Magnitude of -2^(W-1) is 2^(W-1), held as unsigned W-bit, so no overflow.
  - Overflow case -2^(W-1) / -1 gives Quotient = 32'h80000000 and Remainder = 0. This is the wrapped result, with no flag.
  - Divide by zero gives Quotient = 32'hFFFFFFFF, Remainder = A and div_by_zero = 1. This falls out of restoring iteration with |B|=0 and is forced explicitly in FIX, independent of sign fix-up.
  - The remainder sign always equals the dividend sign (or the remainder is 0). |Remainder| < |B| for B≠0.
- start while busy is ignored. It is not queued and does not disturb the operation in flight.
- Quotient, Remainder and div_by_zero hold their last values until the next FIX. A and B may change freely after acceptance.

## Timing
- Reset values are Quotient=0, Remainder=0, busy=0, done=0, div_by_zero=0 and state IDLE. They take effect immediately on rst_n low, with no clock needed.
- Acceptance edge E is the rising edge with state IDLE and start=1.
- CALC iterations run on edges E+1 through E+WIDTH.
- The FIX update is on edge E+WIDTH+1. Results and done=1 are visible after that edge. done=1 lasts exactly one cycle, and busy falls in that same cycle.
- busy=1 after edge E through edge E+WIDTH.
- Latency from acceptance edge to done is WIDTH+1 = 33 cycles, fixed for all operands including divide by zero.
- Back-to-back issue: start may be high in the done cycle. It is accepted on that edge, because the state is already IDLE. Minimum issue interval is WIDTH+2 cycles.
- Reset mid-operation aborts the divide. No done pulse follows, and outputs return to reset values.

## Test plan
- A=-60, B=-3 -> Quotient=20, Remainder=0, done exactly 33 cycles after acceptance, busy high 33 cycles.
- A=6776, B=88 -> Quotient=77, Remainder=0. Then A=-9901, B=99 -> Quotient=-100, Remainder=-1.
- A=7, B=-2 -> Quotient=-3, Remainder=1. Then A=-7, B=2 -> Quotient=-3, Remainder=-1.
- A=98765, B=0 -> Quotient=32'hFFFFFFFF, Remainder=98765, div_by_zero=1. The next divide, 5/1, clears div_by_zero to 0.
- A=32'h80000000, B=-1 -> Quotient=32'h80000000, Remainder=0, div_by_zero=0.
- The bench drives two sequences:
  - start pulsed again mid-CALC with different operands -> ignored, original result returned.
  - rst_n low at cycle 10 of CALC -> no done pulse, all outputs 0, a new start afterwards completes normally.
